alu_seq: RTL and testbench

- Parametrised, handshaked successor to the Simple RISC Machine's 16-bit ALU.
- Generalised to WIDTH bits with a 3-bit opcode: ADD, SUB, AND, MVN, three shifts, and a multi-cycle unsigned multiply.
- Result and N/V/Z status are registered.
- Sits between the register-file operand latches (A/B) and the C register; the datapath FSM drives in_valid and waits for out_valid.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_mul_seq.sv | 68 ++++++
 rtl/alu_seq.sv | 159 +++++++++++++++
 tb/tb_alu_seq.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and the ADD/SUB overflow helper for alu_seq.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_MVN = 3'b011;
    localparam logic [2:0] OP_LSL = 3'b100;
    localparam logic [2:0] OP_LSR = 3'b101;
    localparam logic [2:0] OP_ASR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Two's-complement overflow from the operand and result sign bits.
    function automatic logic add_sub_v(input logic a_msb, input logic b_msb,
                                       input logic r_msb, input logic is_sub);
        if (is_sub)
            return (a_msb != b_msb) && (r_msb != a_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake between the datapath FSM (master) and alu_seq (slave).
interface alu_seq_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ALUop;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic [WIDTH-1:0] out;
    logic             N;
    logic             V;
    logic             Z;
    logic             out_valid;

    modport master (
        output in_valid, ALUop, Ain, Bin,
        input  in_ready, out, N, V, Z, out_valid
    );

    modport slave (
        input  in_valid, ALUop, Ain, Bin,
        output in_ready, out, N, V, Z, out_valid
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, always WIDTH steps.
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH);

    logic               busy_q,   busy_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign prod = acc_q;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can leave it unassigned (latch).
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
        end else if (busy_q) begin
            if (mplier_q[0])
                acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (done)
                busy_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result and N/V/Z flags.
// Define ALU_MUL_EN to build the multi-cycle multiplier for op 111; otherwise op 111 yields zero.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             n_q, n_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] res;
    logic             res_v;

`ifdef ALU_MUL_EN
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .a     (bus.Ain),
        .b     (bus.Bin),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );
`endif

    assign bus.in_ready  = (state_q == S_IDLE);
    assign accept        = bus.in_valid && (state_q == S_IDLE);
    assign bus.out       = out_q;
    assign bus.N         = n_q;
    assign bus.V         = v_q;
    assign bus.Z         = z_q;
    assign bus.out_valid = out_valid_q;

    // Result from the captured operands; only sampled while in S_DONE.
    always_comb begin
        res   = '0;
        res_v = 1'b0;
        sh    = b_q[SHW-1:0];
        case (op_q)
            OP_ADD: begin
                res   = a_q + b_q;
                res_v = add_sub_v(a_q[WIDTH-1], b_q[WIDTH-1], res[WIDTH-1], 1'b0);
            end
            OP_SUB: begin
                res   = a_q - b_q;
                res_v = add_sub_v(a_q[WIDTH-1], b_q[WIDTH-1], res[WIDTH-1], 1'b1);
            end
            OP_AND: res = a_q & b_q;
            OP_MVN: res = ~b_q;
            OP_LSL: res = a_q << sh;
            OP_LSR: res = a_q >> sh;
            OP_ASR: res = $signed(a_q) >>> sh;
            OP_MUL: begin
`ifdef ALU_MUL_EN
                res   = mul_prod[WIDTH-1:0];
                res_v = |mul_prod[2*WIDTH-1:WIDTH];
`else
                res   = '0;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        out_d       = out_q;
        n_d         = n_q;
        v_d         = v_q;
        z_d         = z_q;
        out_valid_d = 1'b0;
`ifdef ALU_MUL_EN
        mul_start   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = bus.ALUop;
                    a_d     = bus.Ain;
                    b_d     = bus.Bin;
                    state_d = S_DONE;
`ifdef ALU_MUL_EN
                    if (bus.ALUop == OP_MUL) begin
                        state_d   = S_MUL;
                        mul_start = 1'b1;
                    end
`endif
                end
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                // An idle multiplier here can only follow a glitch; leave rather than hang.
                if (mul_done || !mul_busy)
                    state_d = S_DONE;
            end
`endif
            S_DONE: begin
                state_d     = S_IDLE;
                out_d       = res;
                n_d         = res[WIDTH-1];
                v_d         = res_v;
                z_d         = (res == '0);
                out_valid_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_q       <= '0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            n_q         <= n_d;
            v_q         <= v_d;
            z_q         <= z_d;
            out_valid_q <= out_valid_d;
        end
    end

    // NOTE: operand latches are always written before they are read, so they need no reset.
    always_ff @(posedge clk) begin
        op_q <= op_d;
        a_q  <= a_d;
        b_q  <= b_d;
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16): per-cycle comparison against an arithmetic model
// plus literal expectations for each directed vector.
module tb_alu_seq;

    localparam int W = 16;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int MUL_LAT  = MUL_EN ? W + 1 : 1;
    localparam int RST_WAIT = MUL_EN ? 8 : 0;

    logic clk;
    logic reset;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [15:0] r;
        logic        n;
        logic        v;
        logic        z;
    } res_t;

    // Expected result from plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int          sa;
        int          sb;
        int          s;
        int          sh;
        longint      p;
        logic [15:0] r;
        logic        v;
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(b) % W;
        v  = 1'b0;
        r  = '0;
        case (op)
            3'd0: begin s = sa + sb; r = 16'(s); v = (s > 32767) || (s < -32768); end
            3'd1: begin s = sa - sb; r = 16'(s); v = (s > 32767) || (s < -32768); end
            3'd2: r = a & b;
            3'd3: r = ~b;
            3'd4: r = 16'(int'(a) << sh);
            3'd5: r = 16'(int'(a) >> sh);
            3'd6: r = 16'(sa >>> sh);
            default: begin
                p = longint'(a) * longint'(b);
                if (MUL_EN) begin
                    r = 16'(p);
                    v = (p > 65535);
                end
            end
        endcase
        return '{r, r[15], v, (r == 16'd0)};
    endfunction

    int   ecnt      = 0;
    int   next_free = 0;
    bit   pend      = 1'b0;
    int   pend_edge = 0;
    res_t pend_res  = '0;
    bit   exp_valid = 1'b0;
    res_t held      = '0;

    initial begin : model_p
        int lat;
        forever begin
            @(posedge clk);
            ecnt++;
            exp_valid = 1'b0;
            if (reset) begin
                pend      = 1'b0;
                next_free = 0;
                held      = '0;
            end else begin
                if (pend && pend_edge == ecnt) begin
                    held      = pend_res;
                    exp_valid = 1'b1;
                    pend      = 1'b0;
                end
                if (bus.in_valid && ecnt >= next_free) begin
                    lat       = (bus.ALUop == 3'd7) ? MUL_LAT : 1;
                    pend      = 1'b1;
                    pend_edge = ecnt + lat;
                    pend_res  = model(bus.ALUop, bus.Ain, bus.Bin);
                    next_free = ecnt + lat + 1;
                end
            end
        end
    end

    initial begin : compare_p
        res_t e;
        bit   ev;
        bit   er;
        forever begin
            @(negedge clk);
            e  = reset ? res_t'(0) : held;
            ev = reset ? 1'b0 : exp_valid;
            er = reset ? 1'b1 : (ecnt + 1 >= next_free);
            check("cyc_out_valid", bus.out_valid, ev);
            check("cyc_in_ready", bus.in_ready, er);
            check("cyc_out", bus.out, e.r);
            check("cyc_N", bus.N, e.n);
            check("cyc_V", bus.V, e.v);
            check("cyc_Z", bus.Z, e.z);
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        n;
        logic        v;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("ready_timeout", bus.in_ready, 1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", bus.out_valid, 1);
    endtask

    task automatic run_op(input vec_t t);
        time t_acc;
        int  lat_exp;
        wait_ready();
        #1;
        bus.ALUop    = t.op;
        bus.Ain      = t.a;
        bus.Bin      = t.b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        t_acc = $time;
        #1 bus.in_valid = 1'b0;
        wait_valid();
        lat_exp = (t.op == 3'd7) ? MUL_LAT : 1;
        check("latency_edges", 32'(($time - t_acc - 5) / 10), lat_exp);
        check("vec_out", bus.out, t.r);
        check("vec_N", bus.N, t.n);
        check("vec_V", bus.V, t.v);
        check("vec_Z", bus.Z, t.z);
    endtask

    initial begin : stim_p
        time t0;
        time t1;
        int  pulses;

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.ALUop    = 3'd0;
        bus.Ain      = '0;
        bus.Bin      = '0;
        #1;
        check("rst_out", bus.out, 0);
        check("rst_Z", bus.Z, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        vecs.push_back('{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{3'd6, 16'h8000, 16'h0004, 16'hF800, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd4, 16'h0001, 16'h00F0, 16'h0001, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd4, 16'h0001, 16'h000F, 16'h8000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd6, 16'h8000, 16'h000F, 16'hFFFF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 16'h8000, 16'h0014, 16'h0800, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd3, 16'h1234, 16'h00FF, 16'hFF00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0});
`ifdef ALU_MUL_EN
        vecs.push_back('{3'd7, 16'd300,  16'd200,  16'hEA60, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3'd7, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{3'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd7, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{3'd7, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0});
`else
        vecs.push_back('{3'd7, 16'd300,  16'd200,  16'h0000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{3'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1});
`endif

        foreach (vecs[i]) run_op(vecs[i]);

        // in_valid held high with fresh operands while the first op is still in flight
        wait_ready();
        #1;
        bus.ALUop    = 3'd7;
        bus.Ain      = 16'd3;
        bus.Bin      = 16'd5;
        bus.in_valid = 1'b1;
        @(posedge clk);
        t0 = $time;
        #1;
        bus.ALUop = 3'd0;
        bus.Ain   = 16'd2;
        bus.Bin   = 16'd3;
        wait_ready();
        @(posedge clk);
        t1 = $time;
        #1 bus.in_valid = 1'b0;
        check("hs_accept_gap", 32'((t1 - t0) / 10), MUL_EN ? W + 2 : 2);
        wait_valid();
        check("hs_out", bus.out, 16'd5);

        repeat (5) @(negedge clk);
        check("hold_out", bus.out, 16'd5);
        check("hold_out_valid", bus.out_valid, 0);

        // reset part-way through an operation
        wait_ready();
        #1;
        bus.ALUop    = 3'd7;
        bus.Ain      = 16'd300;
        bus.Bin      = 16'd200;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (RST_WAIT) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_out", bus.out, 0);
        check("midrst_N", bus.N, 0);
        check("midrst_V", bus.V, 0);
        check("midrst_Z", bus.Z, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        pulses = 0;
        repeat (W + 6) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        check("no_pulse_after_reset", pulses, 0);

        run_op('{3'd0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0});

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
